// File: rtl/chase_pkg.sv
// Shared types and constants for the LED chase run/pause/step controller.
package chase_pkg;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2
    } chase_state_t;

    localparam int unsigned SPEED_W = 3;
    localparam int unsigned PER_W   = 7;
    localparam int unsigned LAP_W   = 8;

    localparam logic [SPEED_W-1:0] SPEED_MAX   = 3'd7;
    localparam logic [SPEED_W-1:0] SPEED_MIN   = 3'd0;
    localparam logic [SPEED_W-1:0] SPEED_RESET = 3'd4;

    // Terminal period-counter value: 2^(7-speed) base ticks per advance, minus one.
    function automatic logic [PER_W-1:0] period_last(input logic [SPEED_W-1:0] spd);
        logic [PER_W:0] len;
        len = 8'd128 >> spd;
        return PER_W'(len - 8'd1);
    endfunction

endpackage

// File: rtl/chase_ctrl_tick_gen.sv
// Prescaler: divides clk down to a one-cycle base tick while enabled.
module tick_gen #(
    parameter int unsigned DIV = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    // Count freezes while disabled so a resumed run keeps its phase unless cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/chase_ctrl.sv
// Run/pause/step and speed controller producing the shifter advance strobe and lap pulse.
module chase_ctrl
    import chase_pkg::*;
#(
    parameter int unsigned BASE_DIV = 1_000_000,
    parameter int unsigned LAP_LEN  = 30
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               btn_run,
    input  logic               btn_step,
    input  logic               btn_faster,
    input  logic               btn_slower,
    output logic               adv,
    output logic               hold,
    output logic               running,
    output logic [SPEED_W-1:0] speed,
    output logic               lap
);

    localparam logic [LAP_W-1:0] LAP_LAST = LAP_W'(LAP_LEN - 1);

    chase_state_t     state;
    logic [PER_W-1:0] per_cnt;
    logic [LAP_W-1:0] lap_cnt;

    logic base_tick;
    logic in_run;
    logic run_start;
    logic speed_up;
    logic speed_dn;
    logic speed_chg;
    logic per_term;
    logic adv_next;
    logic lap_next;

    tick_gen #(
        .DIV (BASE_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (in_run),
        .clr     (run_start),
        .tick    (base_tick)
    );

    // Decode of this cycle's events; a pause on the terminal tick swallows the advance.
    always_comb begin
        in_run    = 1'b0;
        run_start = 1'b0;
        speed_up  = 1'b0;
        speed_dn  = 1'b0;
        speed_chg = 1'b0;
        per_term  = 1'b0;
        adv_next  = 1'b0;
        lap_next  = 1'b0;

        in_run    = (state == RUN);
        run_start = (state == PAUSED) && btn_run;
        speed_up  = btn_faster && !btn_slower && (speed != SPEED_MAX);
        speed_dn  = btn_slower && !btn_faster && (speed != SPEED_MIN);
        speed_chg = speed_up || speed_dn;
        per_term  = in_run && base_tick && (per_cnt == period_last(speed));
        adv_next  = (state == STEP) || (per_term && !btn_run);
        lap_next  = adv_next && (lap_cnt == LAP_LAST);
    end

    // Run/pause/step state machine; run beats step when both arrive while paused.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= PAUSED;
            running <= 1'b0;
        end else begin
            case (state)
                PAUSED: begin
                    if (btn_run) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (btn_step) begin
                        state   <= STEP;
                        running <= 1'b0;
                    end
                end
                RUN: begin
                    if (btn_run) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end
                end
                STEP: begin
                    state   <= PAUSED;
                    running <= 1'b0;
                end
                default: begin
                    state   <= PAUSED;
                    running <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            speed <= SPEED_RESET;
        end else if (speed_up) begin
            speed <= speed + SPEED_W'(1);
        end else if (speed_dn) begin
            speed <= speed - SPEED_W'(1);
        end
    end

    // Period counter restarts on run entry or any speed change so the new rate takes effect cleanly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            per_cnt <= '0;
        end else if (run_start || speed_chg) begin
            per_cnt <= '0;
        end else if (in_run && base_tick) begin
            if (per_term) begin
                per_cnt <= '0;
            end else begin
                per_cnt <= per_cnt + PER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lap_cnt <= '0;
        end else if (adv_next) begin
            if (lap_next) begin
                lap_cnt <= '0;
            end else begin
                lap_cnt <= lap_cnt + LAP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adv  <= 1'b0;
            hold <= 1'b1;
            lap  <= 1'b0;
        end else begin
            adv  <= adv_next;
            hold <= !adv_next;
            lap  <= lap_next;
        end
    end

endmodule
